// File: rtl/icache_fetch_resp.sv
// icache_fetch_resp: fetch responder for the PC controller.
// Accepts one fetch request at a time and looks it up in a direct-mapped
// instruction cache. A missing line is refilled from DDR, and the matching
// 16-byte line is returned with a one-cycle done pulse.
//
// Ports:
//   clock, reset_n           clock, asynchronous active-low reset
//   pc_index_valid/ready     fetch request handshake, pc_index = fetch address
//   pc_operation_done        one-cycle pulse, fetch_line valid while high
//   fetch_line               returned 16-byte line
//   redirect_valid           aborts the in-flight fetch
//   flush_valid              invalidates every line (fence.i)
//   ddr_req_valid/ready      refill request handshake, ddr_req_addr = line address
//   ddr_resp_valid/data      single-beat refill response
module icache_fetch_resp #(
  parameter int unsigned PC_W     = 64,
  parameter int unsigned LINE_NUM = 64,
  parameter int unsigned LINE_W   = 128
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              pc_index_valid,
  input  logic [PC_W-1:0]   pc_index,
  output logic              pc_index_ready,
  output logic              pc_operation_done,
  output logic [LINE_W-1:0] fetch_line,
  input  logic              redirect_valid,
  input  logic              flush_valid,
  output logic              ddr_req_valid,
  input  logic              ddr_req_ready,
  output logic [PC_W-1:0]   ddr_req_addr,
  input  logic              ddr_resp_valid,
  input  logic [LINE_W-1:0] ddr_resp_data
);

  localparam int unsigned IDX_W = $clog2(LINE_NUM);
  localparam int unsigned TAG_W = PC_W - IDX_W - 4;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StReadCache,
    StMissReq,
    StMissWait,
    StDrain
  } state_e;

  state_e              state_q;
  logic [PC_W-5:0]     req_pc_q;      // line address of the accepted request
  logic [LINE_W-1:0]   fetch_line_q;

  logic [LINE_W-1:0]   data_mem [LINE_NUM];
  logic [TAG_W-1:0]    tag_mem  [LINE_NUM];
  logic [LINE_NUM-1:0] valid_q;

  logic [LINE_W-1:0]   rd_data_q;
  logic [TAG_W-1:0]    rd_tag_q;
  logic                rd_valid_q;

  logic                handshake;
  logic                lookup_hit;
  logic                fill_we;
  logic [IDX_W-1:0]    in_idx;
  logic [IDX_W-1:0]    req_idx;
  logic [TAG_W-1:0]    req_tag;
  logic [3:0]          unused_offset;

  assign in_idx        = pc_index[IDX_W+3:4];
  assign req_idx       = req_pc_q[IDX_W-1:0];
  assign req_tag       = req_pc_q[PC_W-5:IDX_W];
  assign unused_offset = pc_index[3:0];

  // Masked by reset_n so no request is offered while reset is held.
  assign pc_index_ready    = reset_n & (state_q == StIdle) & ~redirect_valid;
  assign handshake         = pc_index_valid & pc_index_ready;
  assign lookup_hit        = rd_valid_q & (rd_tag_q == req_tag);
  assign fill_we           = ddr_resp_valid & ((state_q == StMissWait) | (state_q == StDrain));
  assign pc_operation_done = (state_q == StReadCache) & ~redirect_valid;
  assign fetch_line        = fetch_line_q;
  assign ddr_req_valid     = (state_q == StMissReq);
  assign ddr_req_addr      = {req_pc_q, 4'h0};

  // Line storage. The tag and data arrays need no reset, because valid_q guards every hit.
  always_ff @(posedge clock) begin
    if (fill_we) begin
      data_mem[req_idx] <= ddr_resp_data;
      tag_mem[req_idx]  <= req_tag;
    end
  end

  // A flush wins over a fill written in the same cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
    end else if (flush_valid) begin
      valid_q <= '0;
    end else if (fill_we) begin
      valid_q[req_idx] <= 1'b1;
    end
  end

  // Registered array read, issued on the request handshake. A flush on that
  // same edge must also hide the line from the lookup.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_q  <= '0;
      rd_tag_q   <= '0;
      rd_valid_q <= 1'b0;
    end else if (handshake) begin
      rd_data_q  <= data_mem[in_idx];
      rd_tag_q   <= tag_mem[in_idx];
      rd_valid_q <= valid_q[in_idx] & ~flush_valid;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      req_pc_q     <= '0;
      fetch_line_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (handshake) begin
            req_pc_q <= pc_index[PC_W-1:4];
            state_q  <= StLookup;
          end
        end
        StLookup: begin
          if (redirect_valid) begin
            state_q <= StIdle;
          end else if (lookup_hit) begin
            fetch_line_q <= rd_data_q;
            state_q      <= StReadCache;
          end else begin
            state_q <= StMissReq;
          end
        end
        StReadCache: state_q <= StIdle;
        StMissReq: begin
          // A request accepted in the redirect cycle is still outstanding.
          if (redirect_valid) begin
            state_q <= ddr_req_ready ? StDrain : StIdle;
          end else if (ddr_req_ready) begin
            state_q <= StMissWait;
          end
        end
        StMissWait: begin
          if (ddr_resp_valid) begin
            if (redirect_valid) begin
              state_q <= StIdle;
            end else begin
              fetch_line_q <= ddr_resp_data;
              state_q      <= StReadCache;
            end
          end else if (redirect_valid) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (ddr_resp_valid) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
